// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles every hazard/stall/redirect input and every enable/bubble/PC-load
// output of the pipeline stall/flush controller into one connection.
//
//   Core -> controller : hazard_rs1, hazard_rs2, dcache_stall, icache_stall,
//                        redirect, redirect_pc[XLEN]
//   Controller -> core : en_f/d/e/m, bubble_d/e/m/w, pc_load,
//                        pc_target[XLEN], state[2], stall_cycles[CNT_W],
//                        flush_count[CNT_W]
//
// Modports: master = the pipeline datapath side, slave = the controller.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             hazard_rs1;
   logic             hazard_rs2;
   logic             dcache_stall;
   logic             icache_stall;
   logic             redirect;
   logic [XLEN-1:0]  redirect_pc;

   logic             en_f;
   logic             en_d;
   logic             en_e;
   logic             en_m;
   logic             bubble_d;
   logic             bubble_e;
   logic             bubble_m;
   logic             bubble_w;
   logic             pc_load;
   logic [XLEN-1:0]  pc_target;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output hazard_rs1, hazard_rs2, dcache_stall, icache_stall,
             redirect, redirect_pc,
      input  en_f, en_d, en_e, en_m,
             bubble_d, bubble_e, bubble_m, bubble_w,
             pc_load, pc_target, state, stall_cycles, flush_count
   );

   modport slave (
      input  hazard_rs1, hazard_rs2, dcache_stall, icache_stall,
             redirect, redirect_pc,
      output en_f, en_d, en_e, en_m,
             bubble_d, bubble_e, bubble_m, bubble_w,
             pc_load, pc_target, state, stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush controller of the five-stage core. Turns load-use
// hazards, cache stalls and execute-stage redirects into per-stage register
// enables, valid-clear bubbles and a fetch PC load. A redirect that arrives
// while fetch is stalled is parked in a pending register and replayed the
// first cycle fetch is ready. Saturating stall and flush counters are kept.
//
// Ports:
//   clk  - core clock, all state updates on the rising edge
//   rst  - synchronous, active-low reset
//   bus  - pipeline_ctrl_if.slave (hazard/stall/redirect in,
//          enables/bubbles/pc_load/pc_target/state/counters out)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   pipeline_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LU_STALL   = 2'd1,
      MEM_WAIT   = 2'd2,
      REDIR_PEND = 2'd3
   } state_t;

   state_t           r_state;
   logic [XLEN-1:0]  r_pend_pc;
   logic             r_pending;
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_count;

   state_t           w_next_state;
   logic [XLEN-1:0]  w_next_pend_pc;
   logic             w_next_pending;
   logic             w_stall_inc;
   logic             w_flush_inc;
   logic             w_en_f;
   logic             w_en_d;
   logic             w_en_e;
   logic             w_en_m;
   logic             w_bubble_d;
   logic             w_bubble_e;
   logic             w_bubble_m;
   logic             w_bubble_w;
   logic             w_pc_load;
   logic [XLEN-1:0]  w_pc_target;

   // Registered state: FSM state, the parked redirect target with its
   // pending bit, and the two performance counters. The pending bit is kept
   // separate from the state so a parked redirect survives an intervening
   // data-cache or load-use stall. Counters stop at all-ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state        <= RUN;
         r_pend_pc      <= '0;
         r_pending      <= 1'b0;
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         r_state   <= w_next_state;
         r_pend_pc <= w_next_pend_pc;
         r_pending <= w_next_pending;
         if (w_stall_inc && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
         end
         if (w_flush_inc && (r_flush_count != '1)) begin
            r_flush_count <= r_flush_count + 1'b1;
         end
      end
   end

   // Next-state and output decode, walked in strict priority order. A data
   // cache stall freezes everything up to M, so any redirect or hazard seen
   // then will be re-presented and is ignored. A load-use hazard freezes
   // F/D/E and inserts a bubble into M; a redirect in that cycle is dropped
   // because its operand is stale. A parked redirect is replayed only when
   // neither of those is active. A re-issued redirect to the same parked
   // target is not counted as a second flush.
   always_comb begin
      w_next_state   = RUN;
      w_next_pend_pc = r_pend_pc;
      w_next_pending = r_pending;
      w_stall_inc    = 1'b0;
      w_flush_inc    = 1'b0;
      w_en_f         = 1'b1;
      w_en_d         = 1'b1;
      w_en_e         = 1'b1;
      w_en_m         = 1'b1;
      w_bubble_d     = 1'b0;
      w_bubble_e     = 1'b0;
      w_bubble_m     = 1'b0;
      w_bubble_w     = 1'b0;
      w_pc_load      = 1'b0;
      w_pc_target    = '0;

      if (!rst) begin
         w_en_f     = 1'b0;
         w_en_d     = 1'b0;
         w_en_e     = 1'b0;
         w_en_m     = 1'b0;
         w_bubble_d = 1'b1;
         w_bubble_e = 1'b1;
         w_bubble_m = 1'b1;
         w_bubble_w = 1'b1;
      end else if (bus.dcache_stall) begin
         w_en_f       = 1'b0;
         w_en_d       = 1'b0;
         w_en_e       = 1'b0;
         w_en_m       = 1'b0;
         w_bubble_w   = 1'b1;
         w_stall_inc  = 1'b1;
         w_next_state = MEM_WAIT;
      end else if (bus.hazard_rs1 || bus.hazard_rs2) begin
         w_en_f       = 1'b0;
         w_en_d       = 1'b0;
         w_en_e       = 1'b0;
         w_bubble_m   = 1'b1;
         w_stall_inc  = 1'b1;
         w_next_state = LU_STALL;
      end else if (bus.redirect) begin
         w_bubble_d  = 1'b1;
         w_bubble_e  = 1'b1;
         w_flush_inc = !(r_pending && (bus.redirect_pc == r_pend_pc));
         if (bus.icache_stall) begin
            w_en_f         = 1'b0;
            w_next_pend_pc = bus.redirect_pc;
            w_next_pending = 1'b1;
            w_next_state   = REDIR_PEND;
         end else begin
            w_pc_load      = 1'b1;
            w_pc_target    = bus.redirect_pc;
            w_next_pending = 1'b0;
            w_next_state   = RUN;
         end
      end else if (r_pending) begin
         w_bubble_d = 1'b1;
         if (bus.icache_stall) begin
            w_en_f       = 1'b0;
            w_stall_inc  = 1'b1;
            w_next_state = REDIR_PEND;
         end else begin
            w_pc_load      = 1'b1;
            w_pc_target    = r_pend_pc;
            w_next_pending = 1'b0;
            w_next_state   = RUN;
         end
      end else if (bus.icache_stall) begin
         w_en_f       = 1'b0;
         w_bubble_d   = 1'b1;
         w_stall_inc  = 1'b1;
         w_next_state = RUN;
      end
   end

   assign bus.en_f         = w_en_f;
   assign bus.en_d         = w_en_d;
   assign bus.en_e         = w_en_e;
   assign bus.en_m         = w_en_m;
   assign bus.bubble_d     = w_bubble_d;
   assign bus.bubble_e     = w_bubble_e;
   assign bus.bubble_m     = w_bubble_m;
   assign bus.bubble_w     = w_bubble_w;
   assign bus.pc_load      = w_pc_load;
   assign bus.pc_target    = w_pc_target;
   assign bus.state        = r_state;
   assign bus.stall_cycles = r_stall_cycles;
   assign bus.flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed scenarios for the stall/flush controller: load-use stall, long
// data-cache stall with a held redirect, immediate redirect, redirect parked
// during an icache stall, hazard beating redirect, parked redirect surviving
// a dcache stall, counter saturation (CNT_W=4) and reset mid-REDIR_PEND.
// The driver pushes a hand-computed expectation per cycle; an independent
// monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   typedef struct {
      int          cyc;
      logic [3:0]  en;
      logic [3:0]  bub;
      logic        pcl;
      logic [31:0] pct;
      logic        chk;
      logic [1:0]  st;
      logic [3:0]  stall;
      logic [3:0]  flush;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cycleNum;
   exp_t expQ[$];

   pipeline_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   pipeline_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison; X/Z on the DUT side counts as a mismatch.
   task automatic cmp(input int cyc, input string name,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL cycle %0d %s: got %h expected %h", cyc, name, act, exp);
      end
   endtask

   // Compare the presented outputs against one popped expectation.
   task automatic checkOutput(input exp_t e);
      cmp(e.cyc, "en_fdem",      {28'd0, bus.en_f, bus.en_d, bus.en_e, bus.en_m}, {28'd0, e.en});
      cmp(e.cyc, "bubble_demw",  {28'd0, bus.bubble_d, bus.bubble_e, bus.bubble_m, bus.bubble_w}, {28'd0, e.bub});
      cmp(e.cyc, "pc_load",      {31'd0, bus.pc_load}, {31'd0, e.pcl});
      cmp(e.cyc, "pc_target",    bus.pc_target, e.pct);
      if (e.chk) begin
         cmp(e.cyc, "state",        {30'd0, bus.state}, {30'd0, e.st});
         cmp(e.cyc, "stall_cycles", {28'd0, bus.stall_cycles}, {28'd0, e.stall});
         cmp(e.cyc, "flush_count",  {28'd0, bus.flush_count}, {28'd0, e.flush});
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and queue the
   // expected combinational outputs plus the registered values visible
   // during that cycle.
   task automatic applyStimulus(input logic r, input logic h1, input logic h2,
                                input logic dc, input logic ic, input logic rd,
                                input logic [31:0] rpc,
                                input logic [3:0] en, input logic [3:0] bub,
                                input logic pcl, input logic [31:0] pct,
                                input logic chk, input logic [1:0] st,
                                input logic [3:0] stall, input logic [3:0] flush);
      exp_t e;
      @(posedge clk);
      #1;
      rst              = r;
      bus.hazard_rs1   = h1;
      bus.hazard_rs2   = h2;
      bus.dcache_stall = dc;
      bus.icache_stall = ic;
      bus.redirect     = rd;
      bus.redirect_pc  = rpc;
      e.cyc   = cycleNum;
      e.en    = en;
      e.bub   = bub;
      e.pcl   = pcl;
      e.pct   = pct;
      e.chk   = chk;
      e.st    = st;
      e.stall = stall;
      e.flush = flush;
      expQ.push_back(e);
      cycleNum++;
   endtask

   // Quiet cycle: default outputs expected.
   task automatic idleCycle(input logic [1:0] st, input logic [3:0] stall,
                            input logic [3:0] flush);
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 4'b1111, 4'b0000, 0, 32'h0,
                    1, st, stall, flush);
   endtask

   // Monitor: consumes one expectation per cycle on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   // Directed stimulus.
   initial begin
      int waitCnt;
      checks   = 0;
      errors   = 0;
      cycleNum = 0;
      rst              = 1'b0;
      bus.hazard_rs1   = 1'b0;
      bus.hazard_rs2   = 1'b0;
      bus.dcache_stall = 1'b0;
      bus.icache_stall = 1'b0;
      bus.redirect     = 1'b0;
      bus.redirect_pc  = '0;

      // reset: held outputs, then clean RUN state
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 4'b0000, 4'b1111, 0, 32'h0, 0, 2'd0, 4'd0, 4'd0);
      idleCycle(2'd0, 4'd0, 4'd0);

      // load-use on rs1 for one cycle
      applyStimulus(1, 1, 0, 0, 0, 0, 32'h0, 4'b0001, 4'b0010, 0, 32'h0, 1, 2'd0, 4'd0, 4'd0);
      idleCycle(2'd1, 4'd1, 4'd0);

      // dcache stall 5 cycles with redirect held, then redirect accepted
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 0, 1, 0, 1, 32'h200, 4'b0000, 4'b0001, 0, 32'h0,
                       1, (i == 0) ? 2'd0 : 2'd2, 4'(1 + i), 4'd0);
      end
      applyStimulus(1, 0, 0, 0, 0, 1, 32'h200, 4'b1111, 4'b1100, 1, 32'h200, 1, 2'd2, 4'd6, 4'd0);
      idleCycle(2'd0, 4'd6, 4'd1);

      // immediate redirect to 0x100
      applyStimulus(1, 0, 0, 0, 0, 1, 32'h100, 4'b1111, 4'b1100, 1, 32'h100, 1, 2'd0, 4'd6, 4'd1);
      idleCycle(2'd0, 4'd6, 4'd2);

      // redirect during a 3-cycle icache stall
      applyStimulus(1, 0, 0, 0, 1, 1, 32'h100, 4'b0111, 4'b1100, 0, 32'h0, 1, 2'd0, 4'd6, 4'd2);
      applyStimulus(1, 0, 0, 0, 1, 0, 32'h0,   4'b0111, 4'b1000, 0, 32'h0, 1, 2'd3, 4'd6, 4'd3);
      applyStimulus(1, 0, 0, 0, 1, 0, 32'h0,   4'b0111, 4'b1000, 0, 32'h0, 1, 2'd3, 4'd7, 4'd3);
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0,   4'b1111, 4'b1000, 1, 32'h100, 1, 2'd3, 4'd8, 4'd3);
      idleCycle(2'd0, 4'd8, 4'd3);

      // hazard_rs2 together with redirect: load-use only
      applyStimulus(1, 0, 1, 0, 0, 1, 32'h300, 4'b0001, 4'b0010, 0, 32'h0, 1, 2'd0, 4'd8, 4'd3);
      idleCycle(2'd1, 4'd9, 4'd3);

      // parked redirect survives a dcache stall
      applyStimulus(1, 0, 0, 0, 1, 1, 32'h400, 4'b0111, 4'b1100, 0, 32'h0, 1, 2'd0, 4'd9, 4'd3);
      applyStimulus(1, 0, 0, 1, 1, 0, 32'h0,   4'b0000, 4'b0001, 0, 32'h0, 1, 2'd3, 4'd9, 4'd4);
      applyStimulus(1, 0, 0, 0, 1, 0, 32'h0,   4'b0111, 4'b1000, 0, 32'h0, 1, 2'd2, 4'd10, 4'd4);
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0,   4'b1111, 4'b1000, 1, 32'h400, 1, 2'd3, 4'd11, 4'd4);
      idleCycle(2'd0, 4'd11, 4'd4);

      // plain icache stall
      applyStimulus(1, 0, 0, 0, 1, 0, 32'h0, 4'b0111, 4'b1000, 0, 32'h0, 1, 2'd0, 4'd11, 4'd4);
      idleCycle(2'd0, 4'd12, 4'd4);

      // stall counter saturation at 4'hF
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 0, 0, 1, 0, 32'h0, 4'b0111, 4'b1000, 0, 32'h0,
                       1, 2'd0, ((12 + i) > 15) ? 4'd15 : 4'(12 + i), 4'd4);
      end
      idleCycle(2'd0, 4'd15, 4'd4);

      // reset while a redirect is parked: it is discarded
      applyStimulus(1, 0, 0, 0, 1, 1, 32'h500, 4'b0111, 4'b1100, 0, 32'h0, 1, 2'd0, 4'd15, 4'd4);
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h0,   4'b0000, 4'b1111, 0, 32'h0, 1, 2'd3, 4'd15, 4'd5);
      idleCycle(2'd0, 4'd0, 4'd0);
      idleCycle(2'd0, 4'd0, 4'd0);

      // drain the scoreboard with a bounded wait
      waitCnt = 0;
      while (expQ.size() > 0 && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      #1;
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage pipelined core with caches. It consumes the load-use hazard flags from the execute-stage operand hazard units, cache stall requests and branch redirects from execute. It drives per-stage register enables, bubble (valid-clear) strobes and the fetch PC load. It also holds a redirect that arrives while instruction fetch is stalled, and keeps saturating stall/flush performance counters.

## Interface
- XLEN, 32, PC width
- CNT_W, 32, performance counter width
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- hazard_rs1  in  1  load-use hazard, rs1 operand of instruction in E
- hazard_rs2  in  1  load-use hazard, rs2 operand of instruction in E
- dcache_stall  in  1  data cache miss pending for instruction in M
- icache_stall  in  1  fetch cannot deliver an instruction this cycle
- redirect  in  1  taken branch/jump resolved in E
- redirect_pc  in  XLEN  target for redirect
- en_f, en_d, en_e, en_m  out  1 each  pipeline register enables (PC, IF/ID, ID/EX, EX/MEM)
- bubble_d, bubble_e, bubble_m, bubble_w  out  1 each  clear valid of IF/ID, ID/EX, EX/MEM, MEM/WB on this edge
- pc_load  out  1  fetch loads pc_target on this edge
- pc_target  out  XLEN  redirect target
- state  out  2  FSM state: RUN=0, LU_STALL=1, MEM_WAIT=2, REDIR_PEND=3
- stall_cycles  out  CNT_W  cycles with any stall active
- flush_count  out  CNT_W  accepted redirects

## Operation
- Enables, bubbles, pc_load and pc_target are combinational from inputs and registered state. The state register, pend_pc and the counters are registered.
- Default (no event): all en_*=1, all bubble_*=0, pc_load=0, pc_target=0.
- Priority per cycle, highest first:
  1. dcache_stall: en_f/d/e/m=0, bubble_w=1. Redirect and hazard are ignored, because E is frozen and they re-present next cycle. Next state MEM_WAIT. stall_cycles increments.
  2. hazard_rs1|hazard_rs2: en_f/d/e=0, en_m=1, bubble_m=1. Any redirect is ignored because the branch operand is stale. Next state LU_STALL. stall_cycles increments.
  3. redirect: bubble_d=1, bubble_e=1, all en=1, flush_count increments.
     - If icache_stall=0: pc_load=1, pc_target=redirect_pc, next state RUN.
     - If icache_stall=1: en_f=0, pend_pc<=redirect_pc, next state REDIR_PEND.
  4. state==REDIR_PEND:
     - If icache_stall=1: en_f=0, bubble_d=1, stall_cycles increments.
     - If icache_stall=0: pc_load=1, pc_target=pend_pc, bubble_d=1, next state RUN.
  5. icache_stall: en_f=0, bubble_d=1, stall_cycles increments. Next state RUN.
  6. Otherwise next state RUN.
- REDIR_PEND is left only through rule 4. If rule 1 or 2 fires, pend_pc is retained and the state returns to REDIR_PEND afterwards; a separate pending bit tracks this.
- A redirect arriving in REDIR_PEND overwrites pend_pc and does not increment flush_count twice for the same target.
- Counters saturate at all-ones and never wrap.
- An individual hazard unit's forward path is unaffected; this block only gates registers.

## Timing
- Reset: rst==0 at a rising edge clears the state to RUN, pend_pc and the pending bit to 0, and both counters to 0.
- While rst==0 the outputs are held at: en_*=0, bubble_*=1, pc_load=0, pc_target=0.
- Zero-cycle latency from inputs to enables and bubbles. One-cycle latency to state and counters.
- Load-use costs exactly 1 stall cycle: the load moves M→W and the hazard drops, then W forwarding supplies the operand.
- Redirect with icache ready: the PC is loaded on the same edge. 2 instructions are squashed (D, E).
- Redirect during icache stall of N cycles: pc_load is asserted in the first cycle with icache_stall=0.
- Reset asserted mid-MEM_WAIT or mid-REDIR_PEND: the pending redirect is discarded.

## Test plan
- Load in M, dependent instruction in E (hazard_rs1=1 for 1 cycle) → en_f/d/e=0, en_m=1, bubble_m=1 for that cycle; state=1 next cycle; stall_cycles=1.
- dcache_stall high 5 cycles with redirect=1 held → en_*=0 and bubble_w=1 for 5 cycles, no pc_load, flush_count=0, stall_cycles=5; on the 6th cycle pc_load=1 with pc_target=redirect_pc and flush_count=1.
- redirect=1, redirect_pc=0x0000_0100, icache_stall=0 → pc_load=1, pc_target=0x100, bubble_d=bubble_e=1 in the same cycle.
- redirect with icache_stall=1 for 3 cycles → state=3, en_f=0 and bubble_d=1 each cycle; pc_load=1 with pc_target=0x100 in the first cycle icache_stall=0; state returns to 0.
- Simultaneous hazard_rs2=1 and redirect=1 → load-use response only, flush_count unchanged.
- CNT_W=4 with 20 consecutive stall cycles → stall_cycles saturates at 4'hF. rst=0 for one edge → counters=0, state=0, outputs at their reset values.
